// File: rtl/data_bus_arbiter.sv
// ---------------------------------------------------------------------------
// data_bus_arbiter
//
// Shares the synchronous-read SRAM data bus between two masters and sequences
// each access through address, data and response phases.
//   port 0 : core load/store unit
//   port 1 : debug / DMA master
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   mN_req           request level, held until mN_ack            (N = 0,1)
//   mN_we            1 = write, 0 = read
//   mN_addr          byte address
//   mN_wdata         write data
//   mN_width         00 byte, 01 half, 10 word (11 is illegal)
//   mN_signed        sign-extend narrow reads (done by the memory slices)
//   mN_ack           one-cycle completion pulse
//   mN_err           error flag, valid with mN_ack
//   mN_rdata         read result, held until the next ack to the same port
//   stall_lw         core load stall = m0_req & ~m0_ack
//   data_bus_data    bidirectional data, driven only while writing
//   data_bus_addr    latched address
//   data_bus_mode    00 idle, 01 read, 10 write
//   data_bus_reqw    latched width
//   data_bus_reqs    latched signed flag
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | arbitrate, latch the winning request, check legality
// RD_ADDR | read address phase, mode 01
// RD_DATA | read data phase, mode 01, bus data captured at the closing edge
// WRITE   | write phase, mode 10, write data driven for this cycle only
// RESP    | ack (and err) to the granted port, bus idle
// ---------------------------------------------------------------------------
module data_bus_arbiter #(
   parameter logic [31:0] SRAM_BASE  = 32'h0000_2000,
   parameter logic [31:0] SRAM_SIZE  = 32'h0000_1000,
   parameter logic        FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [1:0]  m0_width,
   input  logic        m0_signed,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [1:0]  m1_width,
   input  logic        m1_signed,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,

   output logic        stall_lw,

   inout  wire  [31:0] data_bus_data,
   output logic [31:0] data_bus_addr,
   output logic [1:0]  data_bus_mode,
   output logic [1:0]  data_bus_reqw,
   output logic        data_bus_reqs
);

   // Window end is computed once; a window reaching 0xFFFFFFFF would wrap here.
   localparam logic [31:0] WIN_LAST = SRAM_BASE + SRAM_SIZE - 32'd1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_ADDR = 3'd1;
   localparam logic [2:0] ST_RD_DATA = 3'd2;
   localparam logic [2:0] ST_WRITE   = 3'd3;
   localparam logic [2:0] ST_RESP    = 3'd4;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;
   localparam logic [1:0] W_BAD  = 2'b11;

   localparam logic [1:0] MODE_IDLE  = 2'b00;
   localparam logic [1:0] MODE_READ  = 2'b01;
   localparam logic [1:0] MODE_WRITE = 2'b10;

   logic [2:0]  state_q,      state_d;
   logic        last_grant_q, last_grant_d;
   logic        port_q,       port_d;
   logic        we_q,         we_d;
   logic [31:0] addr_q,       addr_d;
   logic [31:0] wdata_q,      wdata_d;
   logic [1:0]  width_q,      width_d;
   logic        signed_q,     signed_d;
   logic        err_q,        err_d;
   logic [31:0] rdata0_q,     rdata0_d;
   logic [31:0] rdata1_q,     rdata1_d;

   // Arbitration and request selection
   logic        any_req;
   logic        gnt_port;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [1:0]  sel_width;
   logic        sel_signed;
   logic        sel_out_win;
   logic        sel_misalign;
   logic        sel_illegal;

   always_comb begin
      any_req = m0_req | m1_req;

      // Round-robin favours the port that did not win last; after reset
      // last_grant is 1, so port 0 takes the first contested grant.
      if (m0_req && m1_req) begin
         gnt_port = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      end else begin
         gnt_port = m1_req;
      end

      sel_we     = gnt_port ? m1_we     : m0_we;
      sel_addr   = gnt_port ? m1_addr   : m0_addr;
      sel_wdata  = gnt_port ? m1_wdata  : m0_wdata;
      sel_width  = gnt_port ? m1_width  : m0_width;
      sel_signed = gnt_port ? m1_signed : m0_signed;

      sel_out_win  = (sel_addr < SRAM_BASE) || (sel_addr > WIN_LAST);
      sel_misalign = ((sel_width == W_HALF) && sel_addr[0]) ||
                     ((sel_width == W_WORD) && (sel_addr[1:0] != 2'b00));
      sel_illegal  = sel_out_win || sel_misalign || (sel_width == W_BAD);
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      width_d      = width_q;
      signed_d     = signed_q;
      err_d        = err_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               port_d       = gnt_port;
               last_grant_d = gnt_port;
               we_d         = sel_we;
               addr_d       = sel_addr;
               wdata_d      = sel_wdata;
               width_d      = sel_width;
               signed_d     = sel_signed;
               err_d        = sel_illegal;
               if (sel_illegal) begin
                  state_d = ST_RESP;
               end else if (sel_we) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_RD_ADDR;
               end
            end
         end
         ST_RD_ADDR: begin
            state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            // Memory presents the word during this cycle; it lands in the
            // granted port's holding register at the closing edge.
            if (port_q) begin
               rdata1_d = data_bus_data;
            end else begin
               rdata0_d = data_bus_data;
            end
            state_d = ST_RESP;
         end
         ST_WRITE: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         width_q      <= 2'b00;
         signed_q     <= 1'b0;
         err_q        <= 1'b0;
         rdata0_q     <= 32'h0;
         rdata1_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         width_q      <= width_d;
         signed_q     <= signed_d;
         err_q        <= err_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // Bus side: everything decoded from registered state, so no master input
   // ever reaches the bus combinationally.
   always_comb begin
      case (state_q)
         ST_RD_ADDR, ST_RD_DATA: data_bus_mode = MODE_READ;
         ST_WRITE:               data_bus_mode = MODE_WRITE;
         default:                data_bus_mode = MODE_IDLE;
      endcase
   end

   assign data_bus_data = (state_q == ST_WRITE) ? wdata_q : 32'bz;
   assign data_bus_addr = addr_q;
   assign data_bus_reqw = width_q;
   assign data_bus_reqs = signed_q;

   // Master side
   assign m0_ack   = (state_q == ST_RESP) && !port_q;
   assign m1_ack   = (state_q == ST_RESP) &&  port_q;
   assign m0_err   = m0_ack && err_q;
   assign m1_err   = m1_ack && err_q;
   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;

   assign stall_lw = m0_req && !m0_ack;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Testbench for data_bus_arbiter: directed transactions, expected responses
// queued per port at issue time and checked by an independent monitor.
module tb_data_bus_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // ---------------- DUT A: round-robin, with memory model ----------------
   logic        m0_req, m0_we, m0_signed, m0_ack, m0_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [1:0]  m0_width;
   logic        m1_req, m1_we, m1_signed, m1_ack, m1_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [1:0]  m1_width;
   logic        stall_lw;
   wire  [31:0] bus_data;
   logic [31:0] bus_addr;
   logic [1:0]  bus_mode, bus_reqw;
   logic        bus_reqs;

   data_bus_arbiter #(.SRAM_BASE(32'h2000), .SRAM_SIZE(32'h1000), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_width(m0_width), .m0_signed(m0_signed), .m0_ack(m0_ack), .m0_err(m0_err),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_width(m1_width), .m1_signed(m1_signed), .m1_ack(m1_ack), .m1_err(m1_err),
      .m1_rdata(m1_rdata),
      .stall_lw(stall_lw),
      .data_bus_data(bus_data), .data_bus_addr(bus_addr), .data_bus_mode(bus_mode),
      .data_bus_reqw(bus_reqw), .data_bus_reqs(bus_reqs)
   );

   // Little-endian byte memory with registered read and slice-side extension.
   logic [7:0]  mem [0:4095];
   logic [31:0] mem_rd_q;
   assign bus_data = (bus_mode == 2'b01) ? mem_rd_q : 32'bz;

   always @(posedge clk) begin
      logic [11:0] a;
      a = bus_addr[11:0];
      if (bus_mode == 2'b10) begin
         mem[a] <= bus_data[7:0];
         if (bus_reqw != 2'b00) mem[a + 12'd1] <= bus_data[15:8];
         if (bus_reqw == 2'b10) begin
            mem[a + 12'd2] <= bus_data[23:16];
            mem[a + 12'd3] <= bus_data[31:24];
         end
      end
      if (bus_mode == 2'b01) begin
         case (bus_reqw)
            2'b00:   mem_rd_q <= bus_reqs ? {{24{mem[a][7]}}, mem[a]} : {24'h0, mem[a]};
            2'b01:   mem_rd_q <= bus_reqs ? {{16{mem[a + 12'd1][7]}}, mem[a + 12'd1], mem[a]}
                                          : {16'h0, mem[a + 12'd1], mem[a]};
            default: mem_rd_q <= {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
         endcase
      end
   end

   // ---------------- DUT B: fixed priority, bus left unloaded ----------------
   logic        f_m0_req, f_m0_ack, f_m0_err, f_m1_req, f_m1_ack, f_m1_err, f_stall;
   logic [31:0] f_m0_rdata, f_m1_rdata, f_bus_addr;
   logic [1:0]  f_bus_mode, f_bus_reqw;
   logic        f_bus_reqs;
   wire  [31:0] f_bus_data;

   data_bus_arbiter #(.SRAM_BASE(32'h2000), .SRAM_SIZE(32'h1000), .FIXED_PRIO(1'b1)) u_dut_fp (
      .clk(clk), .reset(reset),
      .m0_req(f_m0_req), .m0_we(1'b1), .m0_addr(32'h2000), .m0_wdata(32'h0000_00A0),
      .m0_width(2'b10), .m0_signed(1'b0), .m0_ack(f_m0_ack), .m0_err(f_m0_err),
      .m0_rdata(f_m0_rdata),
      .m1_req(f_m1_req), .m1_we(1'b1), .m1_addr(32'h2010), .m1_wdata(32'h0000_00B1),
      .m1_width(2'b10), .m1_signed(1'b0), .m1_ack(f_m1_ack), .m1_err(f_m1_err),
      .m1_rdata(f_m1_rdata),
      .stall_lw(f_stall),
      .data_bus_data(f_bus_data), .data_bus_addr(f_bus_addr), .data_bus_mode(f_bus_mode),
      .data_bus_reqw(f_bus_reqw), .data_bus_reqs(f_bus_reqs)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          ack_cyc;
      int          n_wr;
      int          n_rd;
      logic [31:0] wdata;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   qf[$];

   int          n_wr = 0;
   int          n_rd = 0;
   logic [31:0] wr_seen = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic check_ack(input int p, input logic err_a, input logic [31:0] rd_a);
      exp_t e;
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL unexpected_ack port=%0d actual=ack required=no_ack", p);
         return;
      end
      if (p == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("m%0d_ack_cycle", p), cyc, e.ack_cyc);
      chk($sformatf("m%0d_err", p), {31'b0, err_a}, {31'b0, e.err});
      chk($sformatf("m%0d_rdata", p), rd_a, e.rdata);
      chk($sformatf("m%0d_write_cycles", p), n_wr, e.n_wr);
      chk($sformatf("m%0d_read_cycles", p), n_rd, e.n_rd);
      if (e.n_wr != 0) chk($sformatf("m%0d_bus_wdata", p), wr_seen, e.wdata);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            n_wr = 0;
            n_rd = 0;
         end else begin
            if (bus_mode == 2'b10) begin
               n_wr++;
               wr_seen = bus_data;
            end
            if (bus_mode == 2'b01) n_rd++;
            if (m0_req && !m0_ack) chk("stall_lw_waiting", {31'b0, stall_lw}, 32'd1);
            if (m0_ack)            chk("stall_lw_at_ack", {31'b0, stall_lw}, 32'd0);
            if (m0_ack || m1_ack) begin
               chk("ack_overlap", {31'b0, m0_ack & m1_ack}, 32'd0);
               if (m0_ack) check_ack(0, m0_err, m0_rdata);
               if (m1_ack) check_ack(1, m1_err, m1_rdata);
               n_wr = 0;
               n_rd = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset && (f_m0_ack || f_m1_ack)) begin
            if (qf.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL fp_unexpected_ack actual=ack required=no_ack");
            end else begin
               chk("fp_grant_port", {31'b0, f_m1_ack}, qf.pop_front());
               chk("fp_err", {31'b0, f_m0_err | f_m1_err}, 32'd0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Issued one step after a rising edge; the DUT accepts at the next edge
   // and the ack is seen lat cycles later (read 3, write 2, error 1), plus
   // any cycles spent waiting behind the other port.
   task automatic txn(input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] width, input logic sgn,
                      input logic e_err, input logic [31:0] e_rd, input int extra);
      exp_t e;
      int   n;
      int   lat;
      logic got;
      lat       = e_err ? 1 : (we ? 2 : 3);
      e.err     = e_err;
      e.rdata   = e_rd;
      e.ack_cyc = cyc + lat + extra;
      e.n_wr    = (!e_err && we)  ? 1 : 0;
      e.n_rd    = (!e_err && !we) ? 2 : 0;
      e.wdata   = wdata;
      if (p == 0) begin
         q0.push_back(e);
         m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_width = width; m0_signed = sgn;
         m0_req = 1'b1;
      end else begin
         q1.push_back(e);
         m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_width = width; m1_signed = sgn;
         m1_req = 1'b1;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         got = (p == 0) ? m0_ack : m1_ack;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL m%0d_ack_timeout actual=no_ack required=ack", p);
      end
      @(posedge clk);
      #1;
      if (p == 0) m0_req = 1'b0;
      else        m1_req = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int n;
      int acks;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_width = 0; m0_signed = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_width = 0; m1_signed = 0;
      f_m0_req = 0; f_m1_req = 0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_mode", {30'b0, bus_mode}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_reqw_reqs", {29'b0, bus_reqw, bus_reqs}, 32'd0);
      chk("rst_acks", {28'b0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      chk("rst_m1_rdata", m1_rdata, 32'd0);
      chk("rst_stall", {31'b0, stall_lw}, 32'd0);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1;

      // Basic write/read, slice 1 byte reads, illegal accesses on port 0
      txn(0, 1'b1, 32'h2004, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 32'h0000_0000, 0);
      txn(0, 1'b0, 32'h2004, 32'h0,         2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
      txn(0, 1'b1, 32'h2804, 32'h0000_80FF, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
      txn(0, 1'b0, 32'h2805, 32'h0,         2'b00, 1'b1, 1'b0, 32'hFFFF_FF80, 0);
      txn(0, 1'b0, 32'h2805, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0000_0080, 0);
      txn(0, 1'b0, 32'h3000, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0080, 0);
      txn(0, 1'b0, 32'h2002, 32'h0,         2'b10, 1'b0, 1'b1, 32'h0000_0080, 0);
      txn(0, 1'b0, 32'h2004, 32'h0,         2'b11, 1'b0, 1'b1, 32'h0000_0080, 0);

      // Port 1: top-of-window half and byte, below-window and misaligned half
      txn(1, 1'b1, 32'h2FFE, 32'hAAAA_8001, 2'b01, 1'b0, 1'b0, 32'h0000_0000, 0);
      txn(1, 1'b0, 32'h2FFE, 32'h0,         2'b01, 1'b1, 1'b0, 32'hFFFF_8001, 0);
      txn(1, 1'b0, 32'h2FFF, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0000_0080, 0);
      txn(1, 1'b0, 32'h1FFF, 32'h0,         2'b00, 1'b0, 1'b1, 32'h0000_0080, 0);
      txn(1, 1'b0, 32'h2FFF, 32'h0,         2'b01, 1'b0, 1'b1, 32'h0000_0080, 0);

      // Reset while the read sits in RD_DATA: bus released at once, no ack
      m0_we = 1'b0; m0_addr = 32'h2004; m0_width = 2'b10; m0_signed = 1'b0;
      m0_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("pre_reset_mode_read", {30'b0, bus_mode}, 32'd1);
      reset = 1'b0;
      m0_req = 1'b0;
      #1;
      chk("reset_mode_idle", {30'b0, bus_mode}, 32'd0);
      chk("reset_addr_clear", bus_addr, 32'd0);
      chk("reset_m0_rdata", m0_rdata, 32'd0);
      chk("reset_m1_rdata", m1_rdata, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("reset_no_ack", {30'b0, m0_ack, m1_ack}, 32'd0);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      txn(1, 1'b0, 32'h2004, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);

      // Both ports contend: m0, m1, m0, m1 with non-overlapping acks
      fork
         begin
            txn(0, 1'b1, 32'h2100, 32'h1111_1111, 2'b10, 1'b0, 1'b0, 32'h0, 0);
            txn(0, 1'b1, 32'h2104, 32'h2222_2222, 2'b10, 1'b0, 1'b0, 32'h0, 3);
         end
         begin
            txn(1, 1'b1, 32'h2200, 32'h3333_3333, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 3);
            txn(1, 1'b1, 32'h2204, 32'h4444_4444, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 3);
         end
      join
      txn(0, 1'b0, 32'h2204, 32'h0, 2'b10, 1'b0, 1'b0, 32'h4444_4444, 0);
      txn(1, 1'b0, 32'h2104, 32'h0, 2'b10, 1'b0, 1'b0, 32'h2222_2222, 0);

      // Fixed priority: m0 wins every time while requesting, m1 only after
      qf.push_back(0); qf.push_back(0); qf.push_back(0); qf.push_back(1);
      f_m0_req = 1'b1;
      f_m1_req = 1'b1;
      acks = 0;
      n = 0;
      while (acks < 3 && n < 100) begin
         @(negedge clk);
         n++;
         if (f_m0_ack) acks++;
      end
      chk("fp_m0_ack_count", acks, 32'd3);
      @(posedge clk); #1;
      f_m0_req = 1'b0;
      n = 0;
      while (!f_m1_ack && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("fp_m1_served", {31'b0, f_m1_ack}, 32'd1);
      @(posedge clk); #1;
      f_m1_req = 1'b0;

      repeat (6) @(negedge clk);
      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      chk("qf_drained", qf.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Sequences and shares the SRAM data bus (0x2000–0x2FFF, two 2 KiB slices, synchronous read) between two masters: port 0 = core load/store unit, port 1 = debug/DMA master.
- Arbitrates round-robin and drives the bus address, mode, width and signedness. It drives write data onto the bidirectional bus and captures read data one cycle after the read address is presented.
- Returns a one-cycle ack with read data or an error flag. Generates the core's load stall.

Parameters:
- SRAM_BASE, 32'h2000, first byte address of the SRAM window.
- SRAM_SIZE, 32'h1000, window size in bytes; legal range is [SRAM_BASE, SRAM_BASE+SRAM_SIZE-1].
- FIXED_PRIO, 0, 1 = port 0 always wins; 0 = round-robin.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mN_req  in  1  request, N=0,1; level, held until mN_ack.
- mN_we  in  1  1 = write, 0 = read.
- mN_addr  in  32  byte address.
- mN_wdata  in  32  write data.
- mN_width  in  2  00 byte, 01 half, 10 word.
- mN_signed  in  1  sign-extend narrow reads.
- mN_ack  out  1  one-cycle completion pulse.
- mN_err  out  1  valid with ack; out-of-window, misaligned or width 11.
- mN_rdata  out  32  read result; valid with ack, held until next ack to the same port.
- stall_lw  out  1  = m0_req & ~m0_ack.
- data_bus_data  inout  32  driven only in WRITE state, else 32'bz.
- data_bus_addr  out  32  latched address.
- data_bus_mode  out  2  00 idle, 01 read, 10 write.
- data_bus_reqw  out  2  latched width.
- data_bus_reqs  out  1  latched signed flag.

Behaviour:
- Reset (reset=0, immediate): state IDLE; data_bus_mode=00; data_bus_addr/reqw/reqs=0; data_bus_data=z; all ack/err/rdata=0; last_grant=1, so port 0 wins first.
- States: IDLE, RD_ADDR, RD_DATA, WRITE, RESP.
- IDLE:
  - No req: stay.
  - Only one req: grant that port.
  - Both req: grant the port != last_grant (round-robin), or port 0 if FIXED_PRIO=1.
  - On grant: latch addr, wdata, width, signed, we and port id into internal regs; update last_grant.
  - Legality check on the latched request:
    - addr outside the window -> error.
    - width 11 -> error.
    - half with addr[0]=1 -> error.
    - word with addr[1:0]!=0 -> error.
  - Next state: error -> RESP with err=1. Legal read -> RD_ADDR. Legal write -> WRITE.
- RD_ADDR: mode=01, bus addr/reqw/reqs from latched regs -> RD_DATA.
- RD_DATA: mode=01 held; sample data_bus_data at the clock edge into the rdata reg of the granted port -> RESP.
- WRITE: mode=10; data_bus_data=latched wdata for exactly this one cycle -> RESP.
- RESP: mode=00; data_bus_data=z; ack=1 for the granted port only; err as determined -> IDLE.
- Bus outputs are decoded from registered state only; no combinational path from mN_* to the bus.
- Latency, measured from the edge at which IDLE accepts the request:
  - Read: ack 3 cycles later.
  - Write: ack 2 cycles later.
  - Error: ack 1 cycle later.
  - Min throughput: one read per 4 cycles.
- Requests arriving outside IDLE wait; they are never dropped.
- A requester that deasserts req before ack is protocol-illegal. The transaction already latched still completes and acks.
- Same-port back-to-back:
  - After RESP, IDLE re-arbitrates.
  - Under round-robin, a pending other port wins.
  - A lone port is regranted on the first IDLE cycle.
- Address arithmetic is unsigned 32-bit. SRAM_BASE+SRAM_SIZE must not overflow; a window ending at 0xFFFFFFFF is unsupported.
- Reset mid-transaction aborts without ack. A partially issued write may or may not have landed in memory.
- Read data is returned unmodified. Sign/zero extension is done by the memory slices via reqs/reqw.

Test Plan:
- Word write m0 addr 0x2004 data 0xDEADBEEF, then word read 0x2004 -> write ack 2 cycles after accept, bus mode 10 for 1 cycle; read ack 3 cycles after accept, m0_rdata=0xDEADBEEF, err=0.
- Byte read, signed, addr 0x2805 (slice 1) after writing 0x000080FF to 0x2804 -> m0_rdata=0xFFFFFF80; same read unsigned -> 0x00000080.
- m0 and m1 assert req in the same cycle after reset, both held for two transactions each -> grant order m0, m1, m0, m1; acks never overlap; stall_lw high until each m0 ack.
- FIXED_PRIO=1, both ports continuously requesting -> m0 acked every transaction, m1 starved until m0 drops req.
- Illegal accesses:
  - Read 0x3000 -> ack+err 1 cycle after accept; bus mode stays 00; rdata unchanged.
  - Word read 0x2002 -> err.
  - Width 11 -> err.
- Assert reset during RD_DATA -> mode=00 and data z in the same cycle; no ack; after release, a fresh m1 request completes normally with port 1 winning only if m0 is idle.
